// File: rtl/sprite_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sprite_pkg
// Purpose  : Shared state encodings, pixel field widths and sizing helpers
// Revision : 1.0
// ============================================================================
package sprite_pkg;

  localparam int X_W  = 9;
  localparam int Y_W  = 8;
  localparam int C_W  = 3;
  localparam int ST_W = 3;

  typedef logic [ST_W-1:0] state_t;

  localparam state_t S_IDLE       = 3'd0;
  localparam state_t S_ERASE_REQ  = 3'd1;
  localparam state_t S_ERASE_WAIT = 3'd2;
  localparam state_t S_DRAW_REQ   = 3'd3;
  localparam state_t S_DRAW_WAIT  = 3'd4;
  localparam state_t S_NEXT       = 3'd5;

  // Counter/index width that never collapses to zero bits.
  function automatic int clog2_min1(input int value);
    return (value > 1) ? $clog2(value) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sprite_draw_scheduler_frame_timer.sv
`default_nettype none
// ============================================================================
// Module   : frame_timer
// Purpose  : Free-running frame divider with a one-cycle tick on each wrap
// Revision : 1.0
// ============================================================================
module frame_timer
  import sprite_pkg::*;
#(
  parameter int FRAME_DIV = 833333
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int                c_cnt_w = clog2_min1(FRAME_DIV);
  localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(FRAME_DIV - 1);

  logic [c_cnt_w-1:0] r_cnt;
  logic               r_tick;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (r_cnt == c_last) begin
      r_cnt  <= '0;
      r_tick <= 1'b1;
    end else begin
      r_cnt  <= r_cnt + c_cnt_w'(1);
      r_tick <= 1'b0;
    end
  end

  assign tick = r_tick;

endmodule
`default_nettype wire

// File: rtl/sprite_draw_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : sprite_draw_scheduler
// Purpose  : Per-frame erase/draw sequencer multiplexing sprites onto one VGA port
// Revision : 1.0
// ============================================================================
module sprite_draw_scheduler
  import sprite_pkg::*;
#(
  parameter int NUM_SPRITES  = 4,
  parameter int FRAME_DIV    = 833333,
  parameter int ERASE_CYCLES = 44,
  parameter int DRAW_TIMEOUT = 63
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic [NUM_SPRITES-1:0]     draw_signal,
  output logic [NUM_SPRITES-1:0]     erase_signal,
  input  logic [NUM_SPRITES-1:0]     finish,
  input  logic [X_W*NUM_SPRITES-1:0] sprite_x,
  input  logic [Y_W*NUM_SPRITES-1:0] sprite_y,
  input  logic [C_W*NUM_SPRITES-1:0] sprite_colour,
  output logic [X_W-1:0]             x,
  output logic [Y_W-1:0]             y,
  output logic [C_W-1:0]             colour,
  output logic                       plot,
  output logic                       busy,
  output logic                       frame_tick,
  output logic                       timeout_err,
  output logic                       overrun_err
);

  localparam int c_idx_w    = clog2_min1(NUM_SPRITES);
  localparam int c_wait_max = (ERASE_CYCLES > DRAW_TIMEOUT) ? ERASE_CYCLES : DRAW_TIMEOUT;
  localparam int c_wait_w   = clog2_min1(c_wait_max + 1);

  localparam logic [c_idx_w-1:0]  c_idx_last      = c_idx_w'(NUM_SPRITES - 1);
  localparam logic [c_wait_w-1:0] c_erase_last    = c_wait_w'(ERASE_CYCLES);
  localparam logic [c_wait_w-1:0] c_draw_last     = c_wait_w'(DRAW_TIMEOUT);
  localparam logic [c_wait_w-1:0] c_plot_first    = c_wait_w'(3);
  localparam logic [c_wait_w-1:0] c_erase_plot_hi = c_wait_w'(ERASE_CYCLES - 2);

  state_t                  r_state;
  state_t                  w_next;
  logic [c_idx_w-1:0]      r_idx;
  logic [c_wait_w-1:0]     r_wait;
  logic                    r_first;
  logic                    r_timeout;
  logic                    r_overrun;
  logic [X_W-1:0]          r_x;
  logic [Y_W-1:0]          r_y;
  logic [C_W-1:0]          r_colour;
  logic                    r_plot;

  logic                    w_tick;
  logic [NUM_SPRITES-1:0]  w_sel;
  logic [X_W-1:0]          w_x;
  logic [Y_W-1:0]          w_y;
  logic [C_W-1:0]          w_colour;
  logic                    w_fin;
  logic                    w_last;
  logic                    w_plot;

  frame_timer #(
    .FRAME_DIV (FRAME_DIV)
  ) u_frame_timer (
    .clk   (clk),
    .reset (reset),
    .tick  (w_tick)
  );

  // One-hot select of the active sprite and its packed pixel fields.
  always_comb begin
    w_sel    = '0;
    w_x      = '0;
    w_y      = '0;
    w_colour = '0;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      if (r_idx == c_idx_w'(i)) begin
        w_sel[i] = 1'b1;
        w_x      = sprite_x[i*X_W +: X_W];
        w_y      = sprite_y[i*Y_W +: Y_W];
        w_colour = sprite_colour[i*C_W +: C_W];
      end
    end
  end

  assign w_fin  = |(finish & w_sel);
  assign w_last = (r_idx == c_idx_last);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_tick) begin
          w_next = r_first ? S_DRAW_REQ : S_ERASE_REQ;
        end
      end
      S_ERASE_REQ:  w_next = S_ERASE_WAIT;
      S_ERASE_WAIT: begin
        if (r_wait == c_erase_last) begin
          w_next = S_DRAW_REQ;
        end
      end
      S_DRAW_REQ:   w_next = S_DRAW_WAIT;
      S_DRAW_WAIT: begin
        if (w_fin || (r_wait == c_draw_last)) begin
          w_next = S_NEXT;
        end
      end
      S_NEXT: begin
        if (w_last) begin
          w_next = S_IDLE;
        end else begin
          w_next = r_first ? S_DRAW_REQ : S_ERASE_REQ;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    draw_signal  = '0;
    erase_signal = '0;
    busy         = (r_state != S_IDLE);
    w_plot       = 1'b0;
    case (r_state)
      S_ERASE_REQ: erase_signal = w_sel;
      S_ERASE_WAIT: begin
        erase_signal = w_sel;
        w_plot       = (r_wait >= c_plot_first) && (r_wait <= c_erase_plot_hi);
      end
      S_DRAW_REQ:  draw_signal = w_sel;
      S_DRAW_WAIT: begin
        draw_signal = w_sel;
        w_plot      = (r_wait >= c_plot_first) && !w_fin;
      end
      default: ;
    endcase
  end

  // r_wait reads 1 on the first cycle of a wait state and counts up from there.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idx     <= '0;
      r_wait    <= '0;
      r_first   <= 1'b1;
      r_timeout <= 1'b0;
      r_overrun <= 1'b0;
      r_x       <= '0;
      r_y       <= '0;
      r_colour  <= '0;
      r_plot    <= 1'b0;
    end else begin
      r_x      <= w_x;
      r_y      <= w_y;
      r_colour <= w_colour;
      r_plot   <= w_plot;

      if ((r_state == S_IDLE) && w_tick) begin
        r_idx <= '0;
      end else if ((r_state == S_NEXT) && !w_last) begin
        r_idx <= r_idx + c_idx_w'(1);
      end

      if ((r_state == S_NEXT) && w_last) begin
        r_first <= 1'b0;
      end

      if ((w_next == S_ERASE_WAIT) || (w_next == S_DRAW_WAIT)) begin
        r_wait <= (w_next == r_state) ? r_wait + c_wait_w'(1) : c_wait_w'(1);
      end else begin
        r_wait <= '0;
      end

      if ((r_state == S_DRAW_WAIT) && !w_fin && (r_wait == c_draw_last)) begin
        r_timeout <= 1'b1;
      end

      if (w_tick && (r_state != S_IDLE)) begin
        r_overrun <= 1'b1;
      end
    end
  end

  assign x           = r_x;
  assign y           = r_y;
  assign colour      = r_colour;
  assign plot        = r_plot;
  assign frame_tick  = w_tick;
  assign timeout_err = r_timeout;
  assign overrun_err = r_overrun;

endmodule
`default_nettype wire

// File: doc/sprite_draw_scheduler.md
SPRITE_DRAW_SCHEDULER -- requirements
Module: sprite_draw_scheduler

Interface
REQ-001 Parameter NUM_SPRITES, default 4: number of sprite blocks served.
REQ-002 Parameter FRAME_DIV, default 833333: clk cycles per frame period.
REQ-003 Parameter ERASE_CYCLES, default 44: fixed wait per sprite erase, which returns no completion.
REQ-004 Parameter DRAW_TIMEOUT, default 63: maximum cycles to wait for a sprite finish.
REQ-005 Port clk, input, 1: single system clock.
REQ-006 Port reset, input, 1: asynchronous, active-high reset.
REQ-007 Port draw_signal, output, NUM_SPRITES: per-sprite draw request level.
REQ-008 Port erase_signal, output, NUM_SPRITES: per-sprite erase request level.
REQ-009 Port finish, input, NUM_SPRITES: per-sprite draw-complete pulse.
REQ-010 Port sprite_x, input, 9*NUM_SPRITES: packed sprite pixel x; sprite i occupies bits [9i+8:9i].
REQ-011 Port sprite_y, input, 8*NUM_SPRITES: packed sprite pixel y.
REQ-012 Port sprite_colour, input, 3*NUM_SPRITES: packed sprite pixel colour.
REQ-013 Port x, output, 9: pixel x to the VGA adapter.
REQ-014 Port y, output, 8: pixel y to the VGA adapter.
REQ-015 Port colour, output, 3: pixel colour to the VGA adapter.
REQ-016 Port plot, output, 1: VGA write enable.
REQ-017 Port busy, output, 1: high whenever the FSM is outside IDLE.
REQ-018 Port frame_tick, output, 1: one-cycle pulse at each frame boundary.
REQ-019 Port timeout_err, output, 1: sticky flag, set when a sprite fails to finish.
REQ-020 Port overrun_err, output, 1: sticky flag, set when a frame_tick occurs while busy.

Function
REQ-021 The frame counter shall count 0..FRAME_DIV-1, wrap to 0, and pulse frame_tick on the wrap cycle.
REQ-022 The FSM shall have six states:
- IDLE
- ERASE_REQ
- ERASE_WAIT
- DRAW_REQ
- DRAW_WAIT
- NEXT
REQ-023 IDLE shall transition on frame_tick: to DRAW_REQ if first_frame=1, otherwise to ERASE_REQ; the sprite index shall be cleared to 0.
REQ-024 ERASE_REQ shall last one cycle, driving erase_signal[idx]=1, then go to ERASE_WAIT.
REQ-025 ERASE_WAIT shall hold erase_signal[idx]=1 and last exactly ERASE_CYCLES cycles, then go to DRAW_REQ.
REQ-026 DRAW_REQ shall last one cycle with draw_signal[idx]=1 (a rising edge per frame), then go to DRAW_WAIT.
REQ-027 DRAW_WAIT shall hold draw_signal[idx]=1 and go to NEXT on finish[idx]=1, or after DRAW_TIMEOUT cycles, in which case timeout_err is set.
REQ-028 NEXT shall deassert all requests for one cycle, then:
- if idx=NUM_SPRITES-1: clear first_frame and return to IDLE;
- otherwise: increment idx and go to ERASE_REQ, or to DRAW_REQ while first_frame=1.
REQ-029 At most one bit of draw_signal|erase_signal shall be high at any time.
REQ-030 Outputs x, y and colour shall be registered copies of the selected sprite's fields, giving one cycle latency.
REQ-031 plot shall be registered, high in ERASE_WAIT wait-cycles 3..ERASE_CYCLES-2 and in DRAW_WAIT cycles 3.. until finish; it shall be low otherwise.
REQ-032 A finish arriving from a sprite other than idx shall be ignored.
REQ-033 A frame_tick arriving while busy shall set overrun_err and be dropped; the frame in progress continues unaffected.
REQ-034 A finish arriving on the same cycle as the timeout shall be treated as success, with timeout_err not set.

Reset
REQ-035 Reset shall force, asynchronously:
- FSM to IDLE; idx=0; frame counter=0; wait counter=0; first_frame=1;
- draw_signal=0; erase_signal=0; x=0; y=0; colour=0;
- plot=0; busy=0; frame_tick=0; timeout_err=0; overrun_err=0.
REQ-036 Reset asserted mid-sequence shall abort immediately, with the next frame treated as a first frame.

Structure
REQ-037 State encodings and the default widths (X_W=9, Y_W=8, C_W=3) shall live in shared package sprite_pkg.
REQ-038 The frame divider shall be a sub-module, frame_timer (clk, reset, tick).

Verification
REQ-039 With NUM_SPRITES=2, FRAME_DIV=200, and sprite models that finish 43 cycles after draw_signal rises:
- frame 1 shall be draw-only;
- frame 2 shall run erase then draw per sprite;
- each request bit shall rise exactly once per frame.
REQ-040 With sprite 1 never finishing, timeout_err shall rise 63 cycles into its DRAW_WAIT, and the FSM shall reach IDLE.
REQ-041 With FRAME_DIV=50 (shorter than one schedule): overrun_err=1, no request glitch, and the next accepted frame_tick shall start at idx 0.
REQ-042 With sprite_x=17, sprite_y=10, colour=3'b101 on the active sprite: x=17, y=10, colour=5 one cycle later, and plot high only in the specified windows.
REQ-043 Asserting reset during ERASE_WAIT of sprite 1 shall zero all outputs within the same cycle; the next frame shall be draw-only.
REQ-044 Pulsing finish[0] while idx=1 shall leave the FSM in DRAW_WAIT.
